// File: rtl/video_timing.sv
// Raster timing generator: signed H/V counters that run negative through blanking,
// registered sync/enable/start decodes aligned with the counters, and a frame-rate animation time.
module video_timing #(
    parameter int HACTIVE   = 640,
    parameter int HFRONT    = 16,
    parameter int HSYNC     = 96,
    parameter int HBACK     = 48,
    parameter int VACTIVE   = 480,
    parameter int VFRONT    = 10,
    parameter int VSYNC     = 2,
    parameter int VBACK     = 33,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0,
    localparam int HBLANK   = HFRONT + HSYNC + HBACK,
    localparam int HTOTAL   = HACTIVE + HBLANK,
    localparam int VBLANK   = VFRONT + VSYNC + VBACK,
    localparam int VTOTAL   = VACTIVE + VBLANK,
    localparam int HW       = $clog2(HTOTAL) + 1,
    localparam int VW       = $clog2(VTOTAL) + 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 time_en,
    input  logic [1:0]           time_div,
    output logic signed [HW-1:0] counter_h,
    output logic signed [VW-1:0] counter_v,
    output logic [7:0]           cur_time,
    output logic                 hsync,
    output logic                 vsync,
    output logic                 display_en,
    output logic                 line_start,
    output logic                 frame_start
);

    if (HFRONT < 1 || HSYNC < 1 || HBACK < 1 || VFRONT < 1 || VSYNC < 1 || VBACK < 1 ||
        HACTIVE < 1 || VACTIVE < 1 || HTOTAL > 2**(HW-1) || VTOTAL > 2**(VW-1)) begin : g_bad_params
        $error("video_timing: illegal timing parameters");
    end

    localparam logic signed [HW-1:0] H_FIRST  = HW'(-HBLANK);
    localparam logic signed [HW-1:0] H_LAST   = HW'(HACTIVE - 1);
    localparam logic signed [HW-1:0] H_ONE    = HW'(1);
    localparam logic signed [HW-1:0] H_SYNC_S = HW'(-HBLANK + HFRONT);
    localparam logic signed [HW-1:0] H_SYNC_E = HW'(-HBACK - 1);
    localparam logic signed [VW-1:0] V_FIRST  = VW'(-VBLANK);
    localparam logic signed [VW-1:0] V_LAST   = VW'(VACTIVE - 1);
    localparam logic signed [VW-1:0] V_ONE    = VW'(1);
    localparam logic signed [VW-1:0] V_SYNC_S = VW'(-VBLANK + VFRONT);
    localparam logic signed [VW-1:0] V_SYNC_E = VW'(-VBACK - 1);

    logic signed [HW-1:0] counter_h_q, counter_h_d;
    logic signed [VW-1:0] counter_v_q, counter_v_d;
    logic [7:0]           cur_time_q, cur_time_d;
    logic [2:0]           div_cnt_q, div_cnt_d;
    logic                 hsync_q, hsync_d;
    logic                 vsync_q, vsync_d;
    logic                 display_en_q, display_en_d;
    logic                 line_start_q, line_start_d;
    logic                 frame_start_q, frame_start_d;
    logic                 h_wrap, v_wrap, frame_wrap;
    logic [3:0]           div_lim_full;
    logic [2:0]           div_lim;

    // Decodes are computed from the next counter values so they land in the same cycle as the counters.
    always_comb begin
        h_wrap       = (counter_h_q == H_LAST);
        v_wrap       = (counter_v_q == V_LAST);
        frame_wrap   = h_wrap && v_wrap;
        counter_h_d  = h_wrap ? H_FIRST : counter_h_q + H_ONE;
        counter_v_d  = counter_v_q;
        if (h_wrap) begin
            counter_v_d = v_wrap ? V_FIRST : counter_v_q + V_ONE;
        end

        div_lim_full = (4'd1 << time_div) - 4'd1;
        div_lim      = div_lim_full[2:0];
        cur_time_d   = cur_time_q;
        div_cnt_d    = div_cnt_q;
        // >= rather than == so shrinking time_div mid-run advances on the very next frame.
        if (frame_wrap && time_en) begin
            if (div_cnt_q >= div_lim) begin
                cur_time_d = cur_time_q + 8'd1;
                div_cnt_d  = 3'd0;
            end else begin
                div_cnt_d  = div_cnt_q + 3'd1;
            end
        end

        hsync_d       = (counter_h_d >= H_SYNC_S && counter_h_d <= H_SYNC_E) ? HSYNC_POL : ~HSYNC_POL;
        vsync_d       = (counter_v_d >= V_SYNC_S && counter_v_d <= V_SYNC_E) ? VSYNC_POL : ~VSYNC_POL;
        display_en_d  = !counter_h_d[HW-1] && !counter_v_d[VW-1];
        line_start_d  = (counter_h_d == H_FIRST);
        frame_start_d = line_start_d && (counter_v_d == V_FIRST);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            counter_h_q   <= H_LAST;
            counter_v_q   <= V_LAST;
            cur_time_q    <= 8'd0;
            div_cnt_q     <= 3'd0;
            hsync_q       <= ~HSYNC_POL;
            vsync_q       <= ~VSYNC_POL;
            display_en_q  <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            counter_h_q   <= counter_h_d;
            counter_v_q   <= counter_v_d;
            cur_time_q    <= cur_time_d;
            div_cnt_q     <= div_cnt_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            display_en_q  <= display_en_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign counter_h   = counter_h_q;
    assign counter_v   = counter_v_q;
    assign cur_time    = cur_time_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign display_en  = display_en_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

endmodule
